// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder handshake and operand bus.
// master drives requests, slave returns results.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start_in;
  logic             sub_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;

  modport master (
    output start_in, sub_in, a_in, b_in, c_in,
    input  busy_out, done_out, sum_out,
    input  carry_out, ovf_out
  );

  modport slave (
    input  start_in, sub_in, a_in, b_in, c_in,
    output busy_out, done_out, sum_out,
    output carry_out, ovf_out
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract, DIGIT bits per clock,
// LSB slice first, registered carry between slices.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  digit_serial_adder_if.slave bus
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [DIGIT:0]   slice;
  logic             cy_msb;
  logic [WIDTH-1:0] res_nxt;

  // Slice adder; carry into the slice MSB is
  // recovered from the MSB sum bit.
  always_comb begin
    slice = {1'b0, a_q[DIGIT-1:0]}
          + {1'b0, b_q[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, cy_q};
    cy_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1]
           ^ slice[DIGIT-1];
    res_nxt = res_q >> DIGIT;
    res_nxt[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
  end

  // Control FSM, operand shifters and result regs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= bus.a_in;
            b_q     <= bus.sub_in ? ~bus.b_in
                                  : bus.b_in;
            cy_q    <= bus.sub_in | bus.c_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_nxt;
          cy_q  <= slice[DIGIT];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_nxt;
            carry_q <= slice[DIGIT];
            ovf_q   <= cy_msb ^ slice[DIGIT];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = carry_q;
  assign bus.ovf_out   = ovf_q;

endmodule
